cpu_run_monitor: RTL
====================

# cpu_run_monitor

Synthesizable run monitor for the single-cycle CPU. It observes the retire, register-file write and data-memory store streams and counts run cycles. It detects the end sentinel (`jal x0,0`) and evaluates NUM_CHECKS programmable register or memory write checks, reporting pass, fail or timeout. It sits beside `cpu` at top level and serves both simulation self-check and on-board status LEDs.

## Interface
- NUM_CHECKS, 2, number of independent check channels (1..8)
- XLEN, 32, datapath width
- ADDR_WIDTH, 11, DMEM word-address width; also wide enough for a 5-bit register index
- MAX_CYCLES, 20, RUN cycles before timeout (≥2, < 2^CYC_W)
- CYC_W, 16, cycle-counter width
- END_SENTINEL, 32'h0000_006F, instruction word that ends a run
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  one-cycle pulse; arms a new run
- retire_valid  in  1  retire_pc/retire_instr valid this cycle
- retire_pc  in  XLEN  PC of the retiring instruction
- retire_instr  in  XLEN  retiring instruction word
- rf_we  in  1  register-file write enable
- rf_waddr  in  5  register-file write index
- rf_wdata  in  XLEN  register-file write data
- mem_we  in  1  DMEM store enable
- mem_addr  in  XLEN  DMEM byte address
- mem_wdata  in  XLEN  DMEM store data
- chk_is_mem  in  NUM_CHECKS  per channel: 1 = memory check, 0 = register check
- chk_idx  in  NUM_CHECKS*ADDR_WIDTH  per channel: register index (low 5 bits) or DMEM word address; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- chk_value  in  NUM_CHECKS*XLEN  per channel: expected value
- busy  out  1  state == RUN
- done  out  1  state == DONE
- pass  out  1  done && !timeout && hit_mask all ones
- timeout  out  1  run ended without the sentinel
- hit_mask  out  NUM_CHECKS  sticky per-channel match
- cycles  out  CYC_W  RUN-cycle index at end of run
- end_pc  out  XLEN  retire_pc at which the sentinel retired
- misaligned_cnt  out  8  saturating count of stores with mem_addr[1:0] != 0

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset value is IDLE.
- All outputs reset to 0.
- Check configuration inputs must be stable while busy. They are not registered.
- IDLE → RUN on start. On entry, clear cycles, hit_mask, timeout, end_pc and misaligned_cnt.
- DONE → RUN on start, with the same clearing. start while in RUN is ignored.
- Per RUN cycle, for each channel i:
  - Register check: hit when rf_we, rf_waddr == chk_idx[4:0], rf_waddr != 0 and rf_wdata == chk_value.
  - Memory check: hit when mem_we, mem_addr[ADDR_WIDTH+1:2] == chk_idx and mem_wdata == chk_value.
  - A hit sets hit_mask[i]. The bit is sticky until the next run; a later non-matching write does not clear it.
- Misaligned store in RUN: misaligned_cnt increments, saturating at 255. The store is still evaluated against memory checks.
- Sentinel: retire_valid && retire_instr == END_SENTINEL in RUN → DONE. Latch end_pc = retire_pc and cycles = current index. timeout stays 0.
- Timeout: index == MAX_CYCLES−1 with no sentinel in that cycle → DONE, timeout = 1, cycles = MAX_CYCLES.
- Simultaneous events:
  - Sentinel on the last cycle counts as a sentinel, not a timeout.
  - Checks hitting in the sentinel cycle or final cycle are counted.
- Inputs in IDLE and DONE are ignored.
- reset low mid-run → IDLE next edge, all state cleared. It overrides start.

## Timing
- start sampled at edge N → busy = 1 after N. The first monitored cycle is N..N+1, which is index 0.
- All outputs are registered. Event in RUN index k → hit_mask/done/pass visible after the edge that ends cycle k (1-cycle latency).
- Maximum run length is MAX_CYCLES monitored cycles. done asserts no later than MAX_CYCLES+1 edges after start.
- Outputs in DONE hold until start or reset.

## Structure
- Package `cpu_mon_pkg`:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2)
  - `END_SENTINEL_JAL0` = 32'h0000_006F
  - width constant `MISALIGN_W` = 8
- Sub-module `cpu_mon_check`: one channel comprising compare logic and a sticky hit flop with clear. Instantiated NUM_CHECKS times with a generate loop.
- The top level holds the FSM, cycle counter, misaligned counter and end_pc register.

## Test plan
- Nominal pass:
  - Setup: ch0 = reg x6/0x10; ch1 = mem word 16/0xDEADBEEF.
  - Stimulus: x6 ← 0x10 at index 3, store 0x40 ← 0xDEADBEEF at index 5, sentinel at index 7, PC 0x1C.
  - Expected: hit_mask = 2'b11, pass = 1, cycles = 7, end_pc = 0x1C, timeout = 0.
- Timeout: no sentinel, MAX_CYCLES = 20 → done after index 19, timeout = 1, cycles = 20, pass = 0.
- Partial fail: only ch0 hits, sentinel at index 4 → hit_mask = 2'b01, pass = 0, timeout = 0.
- Edge cases:
  - A write to x0 with a matching value does not hit.
  - A store to 0x42 with 0xDEADBEEF hits ch1 (word 16) and sets misaligned_cnt = 1.
  - Sentinel and a ch1 hit at index 19 → timeout = 0, pass = 1.
- Control:
  - reset low at index 4 → outputs 0, IDLE.
  - start pulse while busy → run unaffected.
  - start in DONE → counters and hit_mask cleared, new run proceeds.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// Shared state encoding and constants for the CPU run monitor.
package cpu_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mon_state_e;

   localparam logic [31:0] END_SENTINEL_JAL0 = 32'h0000_006F;
   localparam int          MISALIGN_W        = 8;

endpackage

// File: rtl/cpu_mon_check.sv
// One check channel: compares a register or memory write against the expected
// value and keeps a sticky hit flag that is cleared when a new run is armed.
module cpu_mon_check #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  en_i,
   input  logic                  is_mem_i,
   input  logic [ADDR_WIDTH-1:0] idx_i,
   input  logic [XLEN-1:0]       value_i,
   input  logic                  rf_we_i,
   input  logic [4:0]            rf_waddr_i,
   input  logic [XLEN-1:0]       rf_wdata_i,
   input  logic                  mem_we_i,
   input  logic [ADDR_WIDTH-1:0] mem_word_i,
   input  logic [XLEN-1:0]       mem_wdata_i,
   output logic                  hit_o,
   output logic                  hit_next_o
);

   logic regHit;
   logic memHit;
   logic hit_d;
   logic hit_q;

   // x0 is hardwired to zero in the CPU, so writes to it can never count.
   assign regHit = !is_mem_i && rf_we_i && (rf_waddr_i == idx_i[4:0])
                   && (rf_waddr_i != 5'd0) && (rf_wdata_i == value_i);
   assign memHit = is_mem_i && mem_we_i && (mem_word_i == idx_i)
                   && (mem_wdata_i == value_i);

   always_comb begin
      hit_d = hit_q;
      if (clear_i) begin
         hit_d = 1'b0;
      end else if (en_i && (regHit || memHit)) begin
         hit_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_q <= 1'b0;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign hit_o      = hit_q;
   assign hit_next_o = hit_d;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor for the single-cycle CPU: counts RUN cycles, detects the
// jal x0,0 end sentinel and scores the programmable write checks.
module cpu_run_monitor
   import cpu_mon_pkg::*;
#(
   parameter int              NUM_CHECKS   = 2,
   parameter int              XLEN         = 32,
   parameter int              ADDR_WIDTH   = 11,
   parameter int              MAX_CYCLES   = 20,
   parameter int              CYC_W        = 16,
   parameter logic [XLEN-1:0] END_SENTINEL = XLEN'(END_SENTINEL_JAL0)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             retire_valid,
   input  logic [XLEN-1:0]                  retire_pc,
   input  logic [XLEN-1:0]                  retire_instr,
   input  logic                             rf_we,
   input  logic [4:0]                       rf_waddr,
   input  logic [XLEN-1:0]                  rf_wdata,
   input  logic                             mem_we,
   input  logic [XLEN-1:0]                  mem_addr,
   input  logic [XLEN-1:0]                  mem_wdata,
   input  logic [NUM_CHECKS-1:0]            chk_is_mem,
   input  logic [NUM_CHECKS*ADDR_WIDTH-1:0] chk_idx,
   input  logic [NUM_CHECKS*XLEN-1:0]       chk_value,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic                             timeout,
   output logic [NUM_CHECKS-1:0]            hit_mask,
   output logic [CYC_W-1:0]                 cycles,
   output logic [XLEN-1:0]                  end_pc,
   output logic [MISALIGN_W-1:0]            misaligned_cnt
);

   localparam logic [CYC_W-1:0] LAST_IDX  = CYC_W'(MAX_CYCLES - 1);
   localparam logic [CYC_W-1:0] FULL_RUN  = CYC_W'(MAX_CYCLES);

   mon_state_e            state_q, state_d;
   logic [CYC_W-1:0]      cyc_q, cyc_d;
   logic                  timeout_q, timeout_d;
   logic                  pass_q, pass_d;
   logic [XLEN-1:0]       endPc_q, endPc_d;
   logic [MISALIGN_W-1:0] misalign_q, misalign_d;
   logic [NUM_CHECKS-1:0] hitNext;
   logic                  inRun;
   logic                  armRun;
   logic                  sentinelHit;
   logic                  lastCycle;
   logic                  runEnds;
   logic                  unusedAddrBits;

   assign inRun          = (state_q == RUN);
   assign armRun         = start && !inRun;
   assign sentinelHit    = inRun && retire_valid && (retire_instr == END_SENTINEL);
   assign lastCycle      = inRun && (cyc_q == LAST_IDX);
   assign runEnds        = sentinelHit || lastCycle;
   assign unusedAddrBits = ^mem_addr[XLEN-1:ADDR_WIDTH+2];

   for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_chk
      cpu_mon_check #(
         .XLEN       (XLEN),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_check (
         .clk         (clk),
         .reset       (reset),
         .clear_i     (armRun),
         .en_i        (inRun),
         .is_mem_i    (chk_is_mem[i]),
         .idx_i       (chk_idx[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .value_i     (chk_value[i*XLEN +: XLEN]),
         .rf_we_i     (rf_we),
         .rf_waddr_i  (rf_waddr),
         .rf_wdata_i  (rf_wdata),
         .mem_we_i    (mem_we),
         .mem_word_i  (mem_addr[ADDR_WIDTH+1:2]),
         .mem_wdata_i (mem_wdata),
         .hit_o       (hit_mask[i]),
         .hit_next_o  (hitNext[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)   state_d = RUN;
         RUN:     if (runEnds) state_d = DONE;
         DONE:    if (start)   state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // A sentinel on the last cycle wins over timeout; pass uses this cycle's hits too.
   always_comb begin
      cyc_d      = cyc_q;
      timeout_d  = timeout_q;
      pass_d     = pass_q;
      endPc_d    = endPc_q;
      misalign_d = misalign_q;
      if (armRun) begin
         cyc_d      = '0;
         timeout_d  = 1'b0;
         pass_d     = 1'b0;
         endPc_d    = '0;
         misalign_d = '0;
      end else if (inRun) begin
         if (mem_we && (mem_addr[1:0] != 2'b00) && (misalign_q != '1)) begin
            misalign_d = misalign_q + MISALIGN_W'(1);
         end
         if (sentinelHit) begin
            endPc_d = retire_pc;
            pass_d  = &hitNext;
         end else if (lastCycle) begin
            timeout_d = 1'b1;
            cyc_d     = FULL_RUN;
         end else begin
            cyc_d = cyc_q + CYC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cyc_q      <= '0;
         timeout_q  <= 1'b0;
         pass_q     <= 1'b0;
         endPc_q    <= '0;
         misalign_q <= '0;
      end else begin
         cyc_q      <= cyc_d;
         timeout_q  <= timeout_d;
         pass_q     <= pass_d;
         endPc_q    <= endPc_d;
         misalign_q <= misalign_d;
      end
   end

   assign pass           = pass_q;
   assign timeout        = timeout_q;
   assign cycles         = cyc_q;
   assign end_pc         = endPc_q;
   assign misaligned_cnt = misalign_q;

endmodule
